// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: newgame/play/newball/over FSM, ball counter and BCD score.
// Optional build macro BREAKOUT_EXTRA_BALL_EN: bonus ball on each thousands-digit rollover.
module breakout_game_ctrl #(
   parameter int unsigned BALLS          = 3,
   parameter int unsigned NEWBALL_FRAMES = 120,
   parameter int unsigned OVER_FRAMES    = 180,
   parameter logic [4:0]  START_KEY      = 5'h10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        key_ready,
   input  logic [4:0]  key_code,
   input  logic        hit,
   input  logic        miss,
   output logic        gra_still,
   output logic [1:0]  state,
   output logic [1:0]  balls,
   output logic [15:0] score,
   output logic        game_over
);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   localparam logic [1:0] BALLS_INIT = BALLS[1:0];
   localparam logic [7:0] NB_LOAD    = NEWBALL_FRAMES[7:0];
   localparam logic [7:0] OV_LOAD    = OVER_FRAMES[7:0];

   state_t      state_q, state_d;
   logic [1:0]  balls_q, balls_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  timer_q, timer_d;
   logic        key_ready_d;
   logic        gra_still_d, game_over_d;
   logic        start_press;
   logic [15:0] score_inc;

   // Packed-BCD increment with per-digit carry, saturating at 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign start_press = key_ready & ~key_ready_d & (key_code == START_KEY);
   assign score_inc   = bcd_inc(score_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= NEWGAME;
         balls_q     <= BALLS_INIT;
         score_q     <= '0;
         timer_q     <= '0;
         key_ready_d <= 1'b0;
         gra_still   <= 1'b1;
         game_over   <= 1'b0;
      end else begin
         state_q     <= state_d;
         balls_q     <= balls_d;
         score_q     <= score_d;
         timer_q     <= timer_d;
         key_ready_d <= key_ready;
         gra_still   <= gra_still_d;
         game_over   <= game_over_d;
      end
   end

   always_comb begin
      state_d = state_q;
      balls_d = balls_q;
      score_d = score_q;
      timer_d = timer_q;
      case (state_q)
         NEWGAME: begin
            if (start_press) begin
               score_d = '0;
               balls_d = BALLS_INIT;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (hit) score_d = score_inc;
            if (miss) begin
               if (balls_q > 2'd1) begin
                  balls_d = balls_q - 2'd1;
                  timer_d = NB_LOAD;
                  state_d = NEWBALL;
               end else begin
                  balls_d = '0;
                  timer_d = OV_LOAD;
                  state_d = OVER;
               end
            end
`ifdef BREAKOUT_EXTRA_BALL_EN
            // Bonus applies after the miss; a game-ending miss forfeits it.
            if (hit && (score_inc[15:12] != score_q[15:12]) &&
                (state_d != OVER) && (balls_d != 2'd3))
               balls_d = balls_d + 2'd1;
`endif
         end
         NEWBALL, OVER: begin
            if (frame_tick) begin
               timer_d = timer_q - 8'd1;
               if (timer_q == 8'd1) state_d = (state_q == NEWBALL) ? PLAY : NEWGAME;
            end
         end
         default: state_d = NEWGAME;
      endcase
      gra_still_d = (state_d != PLAY);
      game_over_d = (state_d == OVER);
   end

   assign state = state_q;
   assign balls = balls_q;
   assign score = score_q;

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
Game-sequencing controller for the breakout display path. It owns the newgame/play/newball/over state machine, the ball (lives) counter and the BCD score. It drives the graphics engine's freeze input (gra_still) and exports state, balls and score to the text/seven-segment layers. It sits between the keypad decoder, the graphics hit/miss pulses, and the VGA pixel-mux logic in the top level.

Parameters:
BALLS, 3, balls granted at game start (1..3; balls port is 2 bits).
NEWBALL_FRAMES, 120, frames of pause after a miss before play resumes (1..255).
OVER_FRAMES, 180, frames the OVER state is held before returning to NEWGAME (1..255).
START_KEY, 5'h10, keypad code that starts or continues play.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
frame_tick  input  1  one-clk pulse per video frame (vs edge, synchronised upstream).
key_ready  input  1  keypad ready level; a new press is its 0->1 transition.
key_code  input  5  keypad code, valid while key_ready=1.
hit  input  1  one-clk pulse: ball hit a brick.
miss  input  1  one-clk pulse: ball passed the paddle.
gra_still  output  1  1 = freeze ball/paddle motion.
state  output  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
balls  output  2  balls remaining.
score  output  16  four-digit packed BCD score.
game_over  output  1  1 while state=OVER.

Behaviour:
- Reset (sync, reset=1 at posedge): state=NEWGAME, balls=BALLS, score=0, gra_still=1, game_over=0, frame timer=0, key edge register=0. Reset overrides all other inputs in the same cycle and aborts any state.
- All outputs are registered and update on the clk edge after the qualifying input cycle. No combinational path exists from an input to an output.
- start_press = key_ready & ~key_ready_d & (key_code==START_KEY). key_ready_d is a 1-clk delayed copy. Holding the key produces only one press.
- gra_still=1 in every state except PLAY. game_over = (state==OVER).
- NEWGAME:
  - On start_press: score<=0, balls<=BALLS, go to PLAY.
  - hit and miss are ignored.
  - Score from the previous game stays visible until the start press.
- PLAY:
  - hit: score<=score+1 in BCD with per-digit carry. Saturates at 9999; no wrap.
  - miss with balls>1: balls<=balls-1, timer<=NEWBALL_FRAMES, go to NEWBALL.
  - miss with balls==1: balls<=0, timer<=OVER_FRAMES, go to OVER.
  - hit and miss in the same cycle: both take effect (score increments and the miss is processed).
- NEWBALL:
  - Timer decrements on each frame_tick.
  - When timer==1 and frame_tick=1, go to PLAY. This gives exactly NEWBALL_FRAMES ticks.
  - hit, miss and start_press are ignored.
- OVER:
  - Same countdown with OVER_FRAMES, then go to NEWGAME. balls stays 0 until the next start.
  - hit, miss and start_press are ignored.
- frame_tick outside NEWBALL and OVER has no effect.
- The timer is 8 bits and never underflows: a load always precedes a countdown.

Optional Feature:
Macro BREAKOUT_EXTRA_BALL_EN.
- Defined: in PLAY, a hit that takes the score from a value with thousands digit N to thousands digit N+1 also increments balls, capped at 3. This also applies when a miss occurs in the same cycle: the miss is evaluated against the pre-bonus ball count, and the bonus is then added to the result. If the miss sends the game to OVER, the bonus is discarded.
- Undefined: balls only decrements; no bonus logic is synthesised.

Test Plan:
- Reset, then START_KEY press (key_ready 0->1, code 5'h10) -> next clk state=01, gra_still=0, balls=3, score=16'h0000. Holding key_ready high for 100 clks causes no further effect.
- In PLAY, 10 hit pulses -> score=16'h0010. Score preset to 9999 plus one hit -> score stays 16'h9999.
- In PLAY with balls=3, miss pulse -> state=10, balls=2, gra_still=1. After 119 frame_ticks state=10; on the 120th, state=01.
- Three misses with the pauses between them -> state=11, balls=0, game_over=1. After 180 frame_ticks state=00 with score retained. A start_press during OVER is ignored.
- hit and miss in the same cycle with balls=2, score=0042 -> score=0043, balls=1, state=10. Reset asserted mid-NEWBALL -> next clk state=00, balls=3, score=0.
- (BREAKOUT_EXTRA_BALL_EN) score=0999, balls=2, hit -> score=1000, balls=3. With balls=3 the same hit -> balls stays 3.
